// File: rtl/axi_read_error_resp.sv
// axi_read_error_resp
// Answers a read that the AR decoder rejected. The block captures the ID, length
// and user bits of that read. It waits until every legitimate read of the same
// initiator has drained. It then returns arlen+1 DECERR beats with zero data and
// pulses error_gnt_o once so the decoder can accept the next request.
module axi_read_error_resp #(
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_USER_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,

    // capture side, driven by the AR address decoder
    input  logic                      sample_ardata_info_i,
    input  logic [AXI_ID_WIDTH-1:0]   arid_i,
    input  logic [7:0]                arlen_i,
    input  logic [AXI_USER_WIDTH-1:0] aruser_i,
    input  logic                      outstanding_trans_i,

    // R channel
    output logic                      rvalid_o,
    input  logic                      rready_i,
    output logic [AXI_ID_WIDTH-1:0]   rid_o,
    output logic [AXI_DATA_WIDTH-1:0] rdata_o,
    output logic [1:0]                rresp_o,
    output logic                      rlast_o,
    output logic [AXI_USER_WIDTH-1:0] ruser_o,

    // status back to the decoder
    output logic                      error_gnt_o,
    output logic                      busy_o
);

    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_DRAIN = 2'd1,
        SEND       = 2'd2,
        DONE       = 2'd3
    } state_t;

    state_t                    state;
    state_t                    state_nxt;

    logic [AXI_ID_WIDTH-1:0]   cap_id;
    logic [7:0]                cap_len;
    logic [AXI_USER_WIDTH-1:0] cap_user;
    logic [7:0]                beat_cnt;

    logic                      capture;
    logic                      beat_hs;
    logic                      last_beat;

    // A capture can only start from IDLE. Samples seen in any other state are dropped.
    assign capture   = (state == IDLE) && sample_ardata_info_i;
    assign beat_hs   = (state == SEND) && rready_i;
    assign last_beat = (beat_cnt == cap_len);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. rready_i only steers the state register, never rvalid_o directly.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (sample_ardata_info_i) begin
                    state_nxt = WAIT_DRAIN;
                end
            end
            WAIT_DRAIN: begin
                if (!outstanding_trans_i) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (rready_i && last_beat) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Hold the fields of the rejected read for the whole error burst
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_id   <= '0;
            cap_len  <= '0;
            cap_user <= '0;
        end else if (capture) begin
            cap_id   <= arid_i;
            cap_len  <= arlen_i;
            cap_user <= aruser_i;
        end
    end

    // Beat counter. It stops at cap_len, so arlen=255 yields 256 beats and never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (capture) begin
            beat_cnt <= '0;
        end else if (beat_hs && !last_beat) begin
            beat_cnt <= beat_cnt + 8'd1;
        end
    end

    // Every output is decoded from registered state, so the payload holds steady while stalled
    assign rvalid_o    = (state == SEND);
    assign rid_o       = (state == SEND) ? cap_id   : '0;
    assign ruser_o     = (state == SEND) ? cap_user : '0;
    assign rresp_o     = (state == SEND) ? RESP_DECERR : 2'b00;
    assign rdata_o     = '0;
    assign rlast_o     = (state == SEND) && last_beat;
    assign error_gnt_o = (state == DONE);
    assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_axi_read_error_resp.sv
// Testbench for axi_read_error_resp. It uses randomized IDs, user bits, lengths,
// drain times and ready patterns. A burst-level reference model checks the R
// beats and the grant pulse against what the DUT should produce.
module tb_axi_read_error_resp;

    localparam int IW = 4;
    localparam int DW = 64;
    localparam int UW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          sample = 1'b0;
    logic [IW-1:0] arid = '0;
    logic [7:0]    arlen = '0;
    logic [UW-1:0] aruser = '0;
    logic          outstanding = 1'b0;
    logic          rready = 1'b0;

    logic          rvalid;
    logic [IW-1:0] rid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic [UW-1:0] ruser;
    logic          gnt;
    logic          busy;

    int checks = 0;
    int errors = 0;

    axi_read_error_resp #(
        .AXI_ID_WIDTH  (IW),
        .AXI_DATA_WIDTH(DW),
        .AXI_USER_WIDTH(UW)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .sample_ardata_info_i(sample),
        .arid_i              (arid),
        .arlen_i             (arlen),
        .aruser_i            (aruser),
        .outstanding_trans_i (outstanding),
        .rvalid_o            (rvalid),
        .rready_i            (rready),
        .rid_o               (rid),
        .rdata_o             (rdata),
        .rresp_o             (rresp),
        .rlast_o             (rlast),
        .ruser_o             (ruser),
        .error_gnt_o         (gnt),
        .busy_o              (busy)
    );

    always #5 clk = ~clk;

    // control view {rvalid, rlast, gnt, busy} and full view including payload
    wire [3:0]  ctl = {rvalid, rlast, gnt, busy};
    wire [79:0] obs = {rvalid, rid, ruser, rresp, rdata, rlast, gnt, busy};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Runs one rejected read, starting at a negedge while the DUT is in IDLE.
    // Reference: sample at edge T; WAIT_DRAIN lasts max(1,drain) cycles; then
    // len+1 handshaken beats carry (id,user,DECERR,0) with rlast only on beat len;
    // then a single grant cycle; then IDLE. With abort_at >= 0, reset is asserted
    // once that many beats have completed.
    task automatic burst(input logic [IW-1:0] id, input logic [7:0] len, input logic [UW-1:0] user,
                         input int drain, input bit bp, input bit spur, input int abort_at);
        int          beats;
        int          cyc;
        int          n_wait;
        logic [79:0] exp;
        sample      = 1'b1;
        arid        = id;
        arlen       = len;
        aruser      = user;
        outstanding = (drain > 0);
        rready      = 1'($urandom % 2);
        @(negedge clk);
        sample = 1'b0;
        arid   = IW'($urandom);
        arlen  = 8'($urandom);
        aruser = UW'($urandom);
        n_wait = (drain == 0) ? 1 : drain;
        for (int i = 0; i < n_wait; i++) begin
            checks++;
            if (ctl !== 4'b0001) begin
                errors++;
                $display("FAIL wait_drain cycle %0d: ctl got %b expected %b", i, ctl, 4'b0001);
            end
            if (i == n_wait - 1) outstanding = 1'b0;
            @(negedge clk);
        end
        beats = 0;
        cyc   = 0;
        while (beats <= int'(len) && cyc < 4 * int'(len) + 64) begin
            sample = 1'b0;
            if (abort_at >= 0 && beats == abort_at) begin
                rst_n = 1'b0;
                #1;
                checks++;
                if (obs !== 80'h0) begin
                    errors++;
                    $display("FAIL reset_abort: outputs got %h expected %h", obs, 80'h0);
                end
                return;
            end
            exp = {1'b1, id, user, 2'b11, {DW{1'b0}}, (beats == int'(len)), 1'b0, 1'b1};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL send beat %0d (len %0d): got %h expected %h", beats, len, obs, exp);
            end
            rready      = bp ? 1'($urandom % 2) : 1'b1;
            outstanding = 1'($urandom % 2);
            if (spur && beats == 1) begin
                sample = 1'b1;
                arid   = IW'(9);
                arlen  = 8'($urandom);
                aruser = UW'($urandom);
            end
            if (rready) beats++;
            cyc++;
            @(negedge clk);
        end
        sample      = 1'b0;
        outstanding = 1'b0;
        rready      = 1'($urandom % 2);
        if (beats <= int'(len)) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: beats got %0d expected %0d", beats, int'(len) + 1);
        end
        checks++;
        if (ctl !== 4'b0011) begin
            errors++;
            $display("FAIL done_grant: ctl got %b expected %b", ctl, 4'b0011);
        end
        @(negedge clk);
        checks++;
        if (ctl !== 4'b0000) begin
            errors++;
            $display("FAIL back_to_idle: ctl got %b expected %b", ctl, 4'b0000);
        end
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 80'h0) begin
            errors++;
            $display("FAIL reset_immediate: got %h expected %h", obs, 80'h0);
        end
        sample = 1'b1;
        rready = 1'b1;
        arid   = IW'($urandom);
        arlen  = 8'($urandom);
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== 80'h0) begin
            errors++;
            $display("FAIL reset_held: got %h expected %h", obs, 80'h0);
        end
        sample = 1'b0;
        rst_n  = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== 4'b0000) begin
            errors++;
            $display("FAIL reset_release: ctl got %b expected %b", ctl, 4'b0000);
        end
    endtask

    task automatic test_single_beat();
        burst(IW'(3), 8'd0, UW'($urandom), 0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_drain();
        burst(IW'($urandom), 8'd3, UW'($urandom), 10, 1'b0, 1'b0, -1);
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 4; k++) begin
            burst(IW'($urandom), 8'd2, UW'($urandom), int'($urandom_range(0, 3)), 1'b1, 1'b0, -1);
        end
    endtask

    task automatic test_max_len();
        burst(IW'($urandom), 8'd255, UW'($urandom), 0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_reset_mid();
        burst(IW'($urandom), 8'd7, UW'($urandom), 0, 1'b0, 1'b0, 4);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rready      = 1'($urandom % 2);
            outstanding = 1'($urandom % 2);
            @(negedge clk);
            checks++;
            if (ctl !== 4'b0000) begin
                errors++;
                $display("FAIL post_reset_idle cycle %0d: ctl got %b expected %b", i, ctl, 4'b0000);
            end
        end
        outstanding = 1'b0;
        burst(IW'($urandom), 8'd1, UW'($urandom), 0, 1'b1, 1'b0, -1);
    endtask

    task automatic test_spurious();
        burst(IW'(5), 8'd5, UW'($urandom), 1, 1'b1, 1'b1, -1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (ctl !== 4'b0000) begin
                errors++;
                $display("FAIL spurious_no_second_burst cycle %0d: ctl got %b expected %b", i, ctl, 4'b0000);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            burst(IW'($urandom), 8'($urandom_range(0, 15)), UW'($urandom),
                  int'($urandom_range(0, 3)), 1'($urandom % 2), 1'b0, -1);
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_drain();
        test_backpressure();
        test_max_len();
        test_reset_mid();
        test_spurious();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_read_error_resp.md
AXI_READ_ERROR_RESP -- requirements
Module: axi_read_error_resp

Interface
REQ-001 SHALL have parameter AXI_ID_WIDTH, default 4, meaning width of arid/rid.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 64, meaning width of rdata.
REQ-003 SHALL have parameter AXI_USER_WIDTH, default 6, meaning width of aruser/ruser.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port sample_ardata_info_i, input, 1 bit: capture strobe from the AR address decoder.
REQ-007 SHALL have port arid_i, input, AXI_ID_WIDTH: ID of the rejected read.
REQ-008 SHALL have port arlen_i, input, 8 bits: AXI burst length minus one.
REQ-009 SHALL have port aruser_i, input, AXI_USER_WIDTH: user bits of the rejected read.
REQ-010 SHALL have port outstanding_trans_i, input, 1 bit: high while legitimate reads of this initiator remain in flight.
REQ-011 SHALL have port rvalid_o, output, 1 bit: R channel valid.
REQ-012 SHALL have port rready_i, input, 1 bit: R channel ready.
REQ-013 SHALL have ports rid_o (AXI_ID_WIDTH), rdata_o (AXI_DATA_WIDTH), rresp_o (2), rlast_o (1), ruser_o (AXI_USER_WIDTH), all outputs: R payload.
REQ-014 SHALL have port error_gnt_o, output, 1 bit: completion grant back to the AR decoder.
REQ-015 SHALL have port busy_o, output, 1 bit: high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT_DRAIN, SEND, DONE.
REQ-017 In IDLE, when sample_ardata_info_i=1, the block SHALL register arid_i, arlen_i and aruser_i, clear the beat counter, and enter WAIT_DRAIN.
REQ-018 sample_ardata_info_i in any state other than IDLE SHALL be ignored; captured fields SHALL NOT change.
REQ-019 WAIT_DRAIN SHALL hold while outstanding_trans_i=1 and SHALL move to SEND in the first cycle in which outstanding_trans_i=0.
REQ-020 In SEND, rvalid_o SHALL be 1; rid_o/ruser_o SHALL equal the captured values, rresp_o SHALL be 2'b11 (DECERR), and rdata_o SHALL be all zeros.
REQ-021 rlast_o SHALL be 1 only in SEND, when beat counter == captured arlen.
REQ-022 Once rvalid_o is high, it and all R payload SHALL remain stable until rvalid_o&rready_i=1.
REQ-023 On a beat handshake with counter < arlen, the counter (8 bits) SHALL increment by one.
REQ-024 On a beat handshake with counter == arlen, the FSM SHALL enter DONE; the counter SHALL NOT wrap, so arlen=255 yields exactly 256 beats.
REQ-025 In DONE, error_gnt_o SHALL be 1 for exactly one cycle, rvalid_o SHALL be 0, and the next state SHALL be IDLE.
REQ-026 error_gnt_o SHALL be 0 in every state except DONE.
REQ-027 Minimum latency SHALL be: sample at edge T, WAIT_DRAIN in T+1, first rvalid_o in T+2 (if outstanding_trans_i=0 in T+1).
REQ-028 A zero-wait burst of N=arlen+1 beats SHALL complete in N SEND cycles plus one DONE cycle.
REQ-029 A new sample SHALL be accepted no earlier than the cycle after DONE.
REQ-030 outstanding_trans_i SHALL be ignored outside WAIT_DRAIN; rising in SEND SHALL NOT stall beats.
REQ-031 rvalid_o SHALL be 0 in IDLE, WAIT_DRAIN and DONE.
REQ-032 The block SHALL NOT depend combinationally on rready_i for rvalid_o.

Reset
REQ-033 Asserting rst_n=0 SHALL immediately force IDLE, counter=0, captured fields=0, and rvalid_o, rlast_o, error_gnt_o, busy_o=0, rresp_o=0, and rid_o/rdata_o/ruser_o=0.
REQ-034 A reset mid-burst SHALL abandon the burst; no further beats or grant SHALL be issued after reset release until a new sample.

Verification
REQ-035 Single beat: sample arid=3, arlen=0, outstanding=0, rready=1 -> one beat rid=3, rresp=11, rlast=1 at T+2; error_gnt pulse at T+3; IDLE at T+4.
REQ-036 Drain wait: sample arlen=3, outstanding=1 for 10 cycles -> rvalid stays 0 throughout; 4 beats follow, last with rlast=1, then a one-cycle error_gnt.
REQ-037 Backpressure: arlen=2, rready toggles 0/1 randomly -> exactly 3 handshakes, payload stable while stalled, rlast only on the 3rd.
REQ-038 Max length: arlen=255, rready=1 -> 256 beats, rlast on beat 256 only, no counter wrap, single grant.
REQ-039 Reset mid-burst: arlen=7, assert rst_n=0 after beat 4 -> outputs zero immediately; after release no rvalid/grant until new sample.
REQ-040 Spurious sample: pulse sample with arid=9 during SEND of arid=5 -> all remaining beats carry rid=5; grant count = 1.
